// File: rtl/wm_cycle_sequencer_pkg.sv
// rtl/wm_cycle_sequencer_pkg.sv - shared state codes, default phase lengths and decode helpers
//
// Purpose: common definitions for the washing-machine phase sequencer.
//   wm_state_e       : phase codes as seen on the state output (7 is illegal)
//   *_CYC_DEF        : default phase lengths in clock cycles
//   wm_act_t         : actuator enable bundle
//   next_phase()     : phase order FILL->WASH->DRAIN->RINSE->SPIN->DONE
//   decode_actuators : Moore decode of actuators from phase and pause flag
package wm_cycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RINSE = 3'd4,
    ST_SPIN  = 3'd5,
    ST_DONE  = 3'd6,
    ST_BAD   = 3'd7
  } wm_state_e;

  localparam int FILL_CYC_DEF  = 8;
  localparam int WASH_CYC_DEF  = 16;
  localparam int DRAIN_CYC_DEF = 6;
  localparam int RINSE_CYC_DEF = 10;
  localparam int SPIN_CYC_DEF  = 12;
  localparam int DONE_CYC_DEF  = 4;
  localparam int CNT_W_DEF     = 8;

  typedef struct packed {
    logic water_valve;
    logic motor_on;
    logic motor_fast;
    logic drain_pump;
    logic door_lock;
  } wm_act_t;

  function automatic wm_state_e next_phase(wm_state_e st);
    case (st)
      ST_FILL:  return ST_WASH;
      ST_WASH:  return ST_DRAIN;
      ST_DRAIN: return ST_RINSE;
      ST_RINSE: return ST_SPIN;
      ST_SPIN:  return ST_DONE;
      default:  return ST_IDLE;
    endcase
  endfunction

  function automatic wm_act_t decode_actuators(wm_state_e st, logic pz);
    wm_act_t a;
    a = '0;
    case (st)
      ST_FILL:  begin a.water_valve = 1'b1; a.door_lock = 1'b1; end
      ST_WASH:  begin a.motor_on = 1'b1; a.door_lock = 1'b1; end
      ST_DRAIN: begin a.drain_pump = 1'b1; a.door_lock = 1'b1; end
      ST_RINSE: begin a.water_valve = 1'b1; a.motor_on = 1'b1; a.door_lock = 1'b1; end
      ST_SPIN:  begin a.motor_fast = 1'b1; a.drain_pump = 1'b1; a.door_lock = 1'b1; end
      default:  a = '0;
    endcase
    // Pausing stops every actuator but keeps the door latched.
    if (pz) begin
      a.water_valve = 1'b0;
      a.motor_on    = 1'b0;
      a.motor_fast  = 1'b0;
      a.drain_pump  = 1'b0;
    end
    return a;
  endfunction

endpackage

// File: rtl/wm_btn_edge.sv
// rtl/wm_btn_edge.sv - button synchronizer with rising-edge detect
//
// Purpose: brings a raw asynchronous button into the clk domain through two
// flops and emits a one-cycle press pulse on each rising edge of the
// synchronized level. A level first captured at edge k gives press=1 during
// the cycle after edge k+1, so the consumer acts on it at edge k+2.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset, clears all flops
//   button in  raw button level
//   press  out one-cycle rising-edge pulse
module wm_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = sync2 & ~prev;

endmodule

// File: rtl/wm_cycle_sequencer.sv
// rtl/wm_cycle_sequencer.sv - washing-machine phase sequencer
//
// Purpose: turns start/pause button presses into a timed
// FILL->WASH->DRAIN->RINSE->SPIN->DONE cycle and drives the actuators.
// Ports:
//   clk           in  system clock, rising edge
//   reset         in  asynchronous active-low reset
//   start_button  in  raw start button (async)
//   pause_button  in  raw pause/resume button (async)
//   door_closed   in  door sensor, 1 = closed (synchronous)
//   water_valve   out inlet valve enable
//   motor_on      out agitate-speed motor enable
//   motor_fast    out spin-speed motor enable
//   drain_pump    out drain pump enable
//   door_lock     out door latch, set in FILL..SPIN
//   busy          out 1 whenever not IDLE
//   paused        out pause flag
//   done          out 1 while in DONE
//   state         out current phase code
module wm_cycle_sequencer
  import wm_cycle_sequencer_pkg::*;
#(
  parameter int FILL_CYC  = FILL_CYC_DEF,
  parameter int WASH_CYC  = WASH_CYC_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int RINSE_CYC = RINSE_CYC_DEF,
  parameter int SPIN_CYC  = SPIN_CYC_DEF,
  parameter int DONE_CYC  = DONE_CYC_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_button,
  input  logic       pause_button,
  input  logic       door_closed,
  output logic       water_valve,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       drain_pump,
  output logic       door_lock,
  output logic       busy,
  output logic       paused,
  output logic       done,
  output logic [2:0] state
);

  // Counter load values are length-1 so a phase spans the counts len-1..0.
  localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_CYC - 1);
  localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_CYC - 1);
  localparam logic [CNT_W-1:0] DONE_LD  = CNT_W'(DONE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  wm_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             paused_q;
  logic             start_press;
  logic             pause_press;
  wm_act_t          act;

  wm_btn_edge u_start_edge (
    .clk    (clk),
    .reset  (reset),
    .button (start_button),
    .press  (start_press)
  );

  wm_btn_edge u_pause_edge (
    .clk    (clk),
    .reset  (reset),
    .button (pause_button),
    .press  (pause_press)
  );

  function automatic logic [CNT_W-1:0] phase_load(wm_state_e st);
    case (st)
      ST_FILL:  return FILL_LD;
      ST_WASH:  return WASH_LD;
      ST_DRAIN: return DRAIN_LD;
      ST_RINSE: return RINSE_LD;
      ST_SPIN:  return SPIN_LD;
      ST_DONE:  return DONE_LD;
      default:  return '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      paused_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A simultaneous pause press is ignored here, so start always wins.
          if (start_press && door_closed) begin
            state_q <= ST_FILL;
            cnt_q   <= FILL_LD;
          end
        end
        ST_FILL, ST_WASH, ST_DRAIN, ST_RINSE, ST_SPIN: begin
          if (paused_q) begin
            if (pause_press) begin
              paused_q <= 1'b0;
            end
          end else if (pause_press) begin
            // Entering pause still consumes this cycle's count, but never
            // the final one: the advance waits for the first unpaused cycle.
            paused_q <= 1'b1;
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end else if (cnt_q == '0) begin
            state_q <= next_phase(state_q);
            cnt_q   <= phase_load(next_phase(state_q));
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_DONE: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          cnt_q    <= '0;
          paused_q <= 1'b0;
        end
      endcase
    end
  end

  // Pure decode of registers, so the async reset clears actuators at once.
  assign act         = decode_actuators(state_q, paused_q);
  assign water_valve = act.water_valve;
  assign motor_on    = act.motor_on;
  assign motor_fast  = act.motor_fast;
  assign drain_pump  = act.drain_pump;
  assign door_lock   = act.door_lock;
  assign busy        = (state_q != ST_IDLE);
  assign paused      = paused_q;
  assign done        = (state_q == ST_DONE);
  assign state       = state_q;

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// tb/tb_wm_cycle_sequencer.sv - self-checking bench for wm_cycle_sequencer
module tb_wm_cycle_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_button;
  logic       pause_button;
  logic       door_closed;
  logic       water_valve;
  logic       motor_on;
  logic       motor_fast;
  logic       drain_pump;
  logic       door_lock;
  logic       busy;
  logic       paused;
  logic       done;
  logic [2:0] state;

  wm_cycle_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start_button (start_button),
    .pause_button (pause_button),
    .door_closed  (door_closed),
    .water_valve  (water_valve),
    .motor_on     (motor_on),
    .motor_fast   (motor_fast),
    .drain_pump   (drain_pump),
    .door_lock    (door_lock),
    .busy         (busy),
    .paused       (paused),
    .done         (done),
    .state        (state)
  );

  always #5 clk = ~clk;

  wire [7:0] outv = {water_valve, motor_on, motor_fast, drain_pump,
                     door_lock, busy, paused, done};

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase index, cycles of progress made in it, pause flag,
  // and the last three sampled levels of each button.
  int m_phase;
  int m_el;
  bit m_paused;
  bit sh_s[3];
  bit sh_p[3];
  int len[7] = '{0, 8, 16, 6, 10, 12, 4};

  typedef struct packed {
    logic       s;
    logic       p;
    logic       d;
    logic [7:0] n;
    logic [2:0] st;
    logic [7:0] ov;
  } vec_t;

  vec_t tbl[$];
  int   unp;

  function automatic vec_t mk(logic s, logic p, logic d, int n, int st, logic [7:0] ov);
    vec_t v;
    v.s = s; v.p = p; v.d = d; v.n = 8'(n); v.st = 3'(st); v.ov = ov;
    return v;
  endfunction

  function automatic logic [7:0] exp_out(int ph, bit pz);
    bit run;
    run = !pz;
    return {run && (ph == 1 || ph == 4), run && (ph == 2 || ph == 4), run && ph == 5,
            run && (ph == 3 || ph == 5), ph >= 1 && ph <= 5, ph != 0, pz, ph == 6};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, expv);
  endtask

  task automatic model_reset();
    m_phase = 0; m_el = 0; m_paused = 0;
    for (int i = 0; i < 3; i++) begin sh_s[i] = 0; sh_p[i] = 0; end
  endtask

  task automatic model_edge(input logic s, input logic p, input logic d, input logic r);
    bit st_ev, pz_ev;
    if (!r) begin
      model_reset();
    end else begin
      // A level sampled at edge n-2 that was low at n-3 acts at edge n.
      st_ev = sh_s[1] && !sh_s[2];
      pz_ev = sh_p[1] && !sh_p[2];
      sh_s[2] = sh_s[1]; sh_s[1] = sh_s[0]; sh_s[0] = s;
      sh_p[2] = sh_p[1]; sh_p[1] = sh_p[0]; sh_p[0] = p;
      if (m_phase == 0) begin
        if (st_ev && d) begin m_phase = 1; m_el = 0; end
      end else if (m_phase == 6) begin
        m_el++;
        if (m_el == len[6]) begin m_phase = 0; m_el = 0; end
      end else if (m_paused) begin
        if (pz_ev) m_paused = 0;
      end else if (pz_ev) begin
        m_paused = 1;
        if (m_el + 1 < len[m_phase]) m_el++;
      end else begin
        m_el++;
        if (m_el == len[m_phase]) begin m_phase++; m_el = 0; end
      end
    end
  endtask

  task automatic step(input logic s, input logic p, input logic d, input logic r);
    @(negedge clk);
    check("model", {21'd0, state, outv}, {21'd0, 3'(m_phase), exp_out(m_phase, m_paused)});
    start_button = s; pause_button = p; door_closed = d; reset = r;
    @(posedge clk);
    model_edge(s, p, d, r);
    #1;
  endtask

  task automatic step_cnt(input logic s, input logic p);
    step(s, p, 1'b1, 1'b1);
    if (state == 3'd2 && paused == 1'b0) unp++;
  endtask

  task automatic reset_dut();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
  endtask

  task automatic run_until(input int target, input int limit);
    for (int k = 0; k < limit && state !== 3'(target); k++) step(0, 0, 1, 1);
    check("reach_state", {29'd0, state}, target);
  endtask

  initial begin
    int busy_cnt;
    bit s_lvl, p_lvl, d_lvl, r_lvl;
    int s_hold, p_hold, d_hold;

    reset = 1'b0; start_button = 1'b0; pause_button = 1'b0; door_closed = 1'b0;
    model_reset();

    tbl.push_back(mk(0, 0, 0, 2, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 2, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 4, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 2, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 2, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 1, 1, 8'h8C));
    tbl.push_back(mk(0, 0, 1, 5, 1, 8'h8C));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h8C));
    tbl.push_back(mk(0, 0, 1, 1, 1, 8'h0E));
    tbl.push_back(mk(0, 0, 1, 10, 1, 8'h0E));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h0E));
    tbl.push_back(mk(0, 0, 1, 1, 1, 8'h8C));
    tbl.push_back(mk(0, 0, 1, 1, 2, 8'h4C));
    tbl.push_back(mk(1, 0, 1, 3, 2, 8'h4C));
    tbl.push_back(mk(0, 0, 1, 12, 2, 8'h4C));
    tbl.push_back(mk(0, 0, 1, 1, 3, 8'h1C));
    tbl.push_back(mk(0, 0, 1, 5, 3, 8'h1C));
    tbl.push_back(mk(0, 0, 1, 1, 4, 8'hCC));
    tbl.push_back(mk(0, 0, 1, 9, 4, 8'hCC));
    tbl.push_back(mk(0, 0, 1, 1, 5, 8'h3C));
    tbl.push_back(mk(0, 0, 1, 11, 5, 8'h3C));
    tbl.push_back(mk(0, 0, 1, 1, 6, 8'h05));
    tbl.push_back(mk(0, 1, 1, 2, 6, 8'h05));
    tbl.push_back(mk(0, 0, 1, 1, 6, 8'h05));
    tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 1, 1, 2, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 3, 0, 8'h00));
    tbl.push_back(mk(1, 1, 1, 2, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 1, 1, 8'h8C));

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("reset_state", {21'd0, state, outv}, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < int'(tbl[i].n); c++) step(tbl[i].s, tbl[i].p, tbl[i].d, 1'b1);
      check($sformatf("vec%0d", i), {21'd0, state, outv}, {21'd0, tbl[i].st, tbl[i].ov});
    end

    // Full cycle length seen on busy.
    reset_dut();
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    busy_cnt = 0;
    for (int k = 0; k < 120; k++) begin
      step(0, 0, 1, 1);
      if (busy) busy_cnt++;
    end
    check("busy_len", busy_cnt, 56);
    check("end_idle", {29'd0, state}, 0);

    // Long pause in WASH; unpaused WASH cycles still add up to 16.
    reset_dut();
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    run_until(2, 40);
    unp = (state == 3'd2 && !paused) ? 1 : 0;
    step_cnt(0, 0);
    step_cnt(0, 0);
    step_cnt(0, 1);
    step_cnt(0, 1);
    for (int k = 0; k < 20; k++) step_cnt(0, 0);
    check("pz_motor", {31'd0, motor_on}, 0);
    check("pz_lock", {31'd0, door_lock}, 1);
    check("pz_state", {29'd0, state}, 2);
    check("pz_flag", {31'd0, paused}, 1);
    step_cnt(0, 1);
    step_cnt(0, 1);
    for (int k = 0; k < 40 && state == 3'd2; k++) step_cnt(0, 0);
    check("wash_unpaused", unp, 16);

    // Asynchronous reset in the middle of SPIN.
    reset_dut();
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    run_until(5, 80);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    @(negedge clk);
    check("spin_fast", {31'd0, motor_fast}, 1);
    #1 reset = 1'b0;
    #1;
    check("rst_fast", {31'd0, motor_fast}, 0);
    check("rst_pump", {31'd0, drain_pump}, 0);
    check("rst_lock", {31'd0, door_lock}, 0);
    check("rst_state", {29'd0, state}, 0);
    model_reset();
    @(posedge clk);
    model_edge(0, 0, 1, 0);
    #1;
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    check("post_rst_idle", {29'd0, state}, 0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    check("post_rst_start", {29'd0, state}, 1);

    // Random buttons, door and occasional resets against the model.
    reset_dut();
    s_lvl = 0; p_lvl = 0; d_lvl = 1; s_hold = 0; p_hold = 0; d_hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if (s_hold == 0) begin s_lvl = ($urandom_range(0, 3) == 0); s_hold = $urandom_range(1, 6); end
      if (p_hold == 0) begin p_lvl = ($urandom_range(0, 4) == 0); p_hold = $urandom_range(1, 6); end
      if (d_hold == 0) begin d_lvl = ($urandom_range(0, 7) != 0); d_hold = $urandom_range(1, 20); end
      s_hold--; p_hold--; d_hold--;
      r_lvl = ($urandom_range(0, 399) != 0);
      step(s_lvl, p_lvl, d_lvl, r_lvl);
    end
    step(0, 0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
